soc_cluster_event_tx: RTL
=========================

# soc_cluster_event_tx

Producer side of the SoC-to-cluster event bus. It arbitrates SoC event sources (DMA PE event, DMA PE IRQ, peripheral/FC events, software events) and pushes event IDs into a token-ring buffer. The cluster domain drains that buffer through `cluster_events_wt_o`, `cluster_events_rp_i` and `cluster_events_da_o`. The block sits directly upstream of the SoC domain's event-bus outputs. It runs only on the SoC clock; only `cluster_events_rp_i` arrives from the other domain.

## Interface
- `BUFFER_WIDTH`, 8: ring slots; power of two, ≥4; usable capacity is BUFFER_WIDTH-1.
- `EVNT_WIDTH`, 8: event ID width.
- `N_SRC`, 4: number of event sources.
- `clk_i` in, 1: SoC clock; sole clock.
- `rst_ni` in, 1: reset, synchronous, active-low.
- `evt_valid_i` in, N_SRC: per-source request; held until granted.
- `evt_id_i` in, N_SRC×EVNT_WIDTH: per-source event ID; stable while valid.
- `evt_ready_o` out, N_SRC: one-hot grant; push happens when `valid & ready`.
- `cluster_events_wt_o` out, BUFFER_WIDTH: one-hot write token.
- `cluster_events_rp_i` in, BUFFER_WIDTH: one-hot read pointer from the cluster; asynchronous.
- `cluster_events_da_o` out, EVNT_WIDTH: data of the slot selected by the raw `cluster_events_rp_i`.
- `fill_level_o` out, $clog2(BUFFER_WIDTH): occupied slots as seen locally.
- `rp_err_o` out, 1: sticky flag; synchronized read pointer was not one-hot.

## Operation
**Storage and pointers**
- `buf_q[BUFFER_WIDTH][EVNT_WIDTH]`: event storage.
- `wt_q`: internal one-hot write pointer.
- `wt_o_q`: registered copy of `wt_q`, driven on `cluster_events_wt_o`.
- `rp_s1`, `rp_s2`: two-flop synchronizer on `cluster_events_rp_i`.
- `rp_q`: last valid synchronized read pointer.

**Read-pointer capture**
- If `rp_s2` is one-hot, `rp_q <= rp_s2`.
- Otherwise `rp_q` holds its value and `rp_err_o` sets. `rp_err_o` clears only on reset.

**Status**
- empty = (`wt_q == rp_q`).
- full = (`rotl(wt_q,1) == rp_q`).
- fill_level = (idx(`wt_q`) − idx(`rp_q`)) mod BUFFER_WIDTH.

**Arbitration**
- Round-robin over the `evt_valid_i` bits, starting from `rr_q`.
- Grant is combinational: `evt_ready_o[k]=1` only for the winning k, and only when not full.
- With no valid source, or when full, `evt_ready_o` is all 0.
- On a push by source k, `rr_q <= (k+1) mod N_SRC`. Otherwise `rr_q` holds.

**Push (edge t)**
- `buf_q[idx(wt_q)] <= evt_id_i[k]`.
- `wt_q <= rotl(wt_q,1)`.

**Data output**
- `cluster_events_da_o` is an AND-OR mux of `buf_q` using the raw `cluster_events_rp_i`; no register.
- A slot is never written while it lies between `rp_q` and `wt_q`, so the mux input is stable while the consumer reads it.

**Reset**
- `wt_q`, `wt_o_q`, `rp_s1`, `rp_s2`, `rp_q` = 1 (slot 0).
- `buf_q` = 0, `rr_q` = 0, `rp_err_o` = 0.
- Outputs after reset: `evt_ready_o` = 0 (nothing valid yet), `fill_level_o` = 0, `cluster_events_wt_o` = 1, `cluster_events_da_o` = `buf_q` selected by the raw input (0 after reset).
- Reset mid-operation discards all buffered events. The cluster consumer is reset in the same window; nothing is guaranteed otherwise.

## Timing
- **Push to consumer:** `evt_valid_i` high in cycle 0 with grant gives a push at edge 0. `buf_q` updates at edge 0; `cluster_events_wt_o` updates at edge 1. This one-cycle data-before-token gap is mandatory.
- **Internal pointer use:** full, empty and `fill_level_o` use `wt_q` and reflect a push from the next cycle.
- **Free-space latency:** a change on `cluster_events_rp_i` reaches `rp_q` after three SoC edges (s1, s2, rp_q). Full deasserts three cycles after the consumer advances.
- **Throughput:** one push per cycle, no bubbles, until full. Simultaneous push and rp advance in the same cycle are both applied.
- **Wrap-around:** `wt_q` and `rp_q` rotate from slot BUFFER_WIDTH-1 to slot 0 with no special case.
- **Full:** all grants drop. Sources hold `valid`; no event is lost.

## Test plan
- **Single push:** reset, then source 2 valid with ID 0x5A. Expect `evt_ready_o=4'b0100` in cycle 0, `buf_q[0]=0x5A`, `cluster_events_wt_o=0x02` one cycle later, `fill_level_o=1`.
- **Round-robin:** all 4 sources valid for 4 cycles. Expect grants in order 0,1,2,3. Then with sources 1 and 3 valid and `rr_q`=0, expect grant 1, then 3.
- **Fill to full:** `rp_i` held at 0x01, continuous valid. Expect exactly 7 pushes, `fill_level_o=7`, `evt_ready_o=0`. Move `rp_i` to 0x02; expect a grant exactly 3 cycles later.
- **Wrap:** 20 events streamed with a consumer that advances `rp_i` every 4 cycles. Expect IDs read via `cluster_events_da_o` in order with no loss or duplication, and `wt_o` passing 0x80→0x01.
- **Bad read pointer:** drive `rp_i=0x03` for 3 cycles. Expect `rp_err_o=1` (sticky) and `rp_q` unchanged.
- **Reset mid-stream:** assert reset with `fill_level_o=5`. Expect `wt_o=0x01`, `fill_level_o=0`, `rp_err_o=0` on the next edge.

Source files
------------

// File: rtl/soc_cluster_event_tx.sv
// soc_cluster_event_tx
// Producer side of the SoC-to-cluster event bus. SoC event sources are
// arbitrated round-robin and their IDs are pushed into a token ring. The
// cluster drains the ring with its own one-hot read pointer. Only that read
// pointer crosses clock domains, and it is synchronized here.
module soc_cluster_event_tx #(
  parameter int BUFFER_WIDTH = 8,
  parameter int EVNT_WIDTH   = 8,
  parameter int N_SRC        = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_SRC-1:0]              evt_valid_i,
  input  logic [N_SRC*EVNT_WIDTH-1:0]   evt_id_i,
  output logic [N_SRC-1:0]              evt_ready_o,
  output logic [BUFFER_WIDTH-1:0]       cluster_events_wt_o,
  input  logic [BUFFER_WIDTH-1:0]       cluster_events_rp_i,
  output logic [EVNT_WIDTH-1:0]         cluster_events_da_o,
  output logic [$clog2(BUFFER_WIDTH)-1:0] fill_level_o,
  output logic                          rp_err_o
);

  localparam int IW = $clog2(BUFFER_WIDTH);
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  // Ring storage and pointers
  logic [EVNT_WIDTH-1:0]   buf_q [BUFFER_WIDTH];
  logic [EVNT_WIDTH-1:0]   buf_d [BUFFER_WIDTH];
  logic [BUFFER_WIDTH-1:0] wt_q, wt_d;
  logic [BUFFER_WIDTH-1:0] wt_o_q;
  logic [BUFFER_WIDTH-1:0] rp_s1_q, rp_s2_q;
  logic [BUFFER_WIDTH-1:0] rp_q, rp_d;
  logic                    rp_err_q, rp_err_d;
  logic [SW-1:0]           rr_q, rr_d;

  // Derived status
  logic [BUFFER_WIDTH-1:0] wt_rotl;
  logic [IW-1:0]           wt_idx, rp_idx;
  logic                    full;
  logic                    rp_s2_onehot;

  // Arbitration
  logic                    found;
  logic [SW-1:0]           win;
  logic [SW:0]             cand_sum;
  logic [SW-1:0]           cand;
  logic                    push;
  logic [EVNT_WIDTH-1:0]   push_id;

  // Data mux terms
  logic [EVNT_WIDTH-1:0]   da_terms [BUFFER_WIDTH];

  // One-hot to binary index; OR-based so it costs no priority chain.
  function automatic logic [IW-1:0] oh2idx(input logic [BUFFER_WIDTH-1:0] oh);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < BUFFER_WIDTH; i++) begin
      if (oh[i]) idx = idx | IW'(i);
    end
    return idx;
  endfunction

  assign wt_rotl      = {wt_q[BUFFER_WIDTH-2:0], wt_q[BUFFER_WIDTH-1]};
  assign wt_idx       = oh2idx(wt_q);
  assign rp_idx       = oh2idx(rp_q);
  assign full         = (wt_rotl == rp_q);
  assign rp_s2_onehot = (rp_s2_q != '0) &&
                        ((rp_s2_q & (rp_s2_q - BUFFER_WIDTH'(1))) == '0);

  // Round-robin search starting at rr_q; first valid source wins.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    cand_sum = '0;
    cand     = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cand_sum = {1'b0, rr_q} + (SW+1)'(i);
      if (cand_sum >= (SW+1)'(N_SRC)) cand_sum = cand_sum - (SW+1)'(N_SRC);
      cand = cand_sum[SW-1:0];
      if (!found && evt_valid_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign push = found && !full;

  // Select the winning source's ID for the write.
  always_comb begin
    push_id = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (win == SW'(k)) push_id = evt_id_i[k*EVNT_WIDTH +: EVNT_WIDTH];
    end
  end

  // Grants are one-hot on the winner and suppressed while the ring is full.
  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_ready
      assign evt_ready_o[gi] = push && (win == SW'(gi));
    end
  endgenerate

  // Next-state for pointers, arbiter and storage.
  always_comb begin
    wt_d     = wt_q;
    rr_d     = rr_q;
    rp_d     = rp_q;
    rp_err_d = rp_err_q;
    buf_d    = buf_q;
    if (push) begin
      wt_d          = wt_rotl;
      rr_d          = (win == SW'(N_SRC-1)) ? '0 : win + 1'b1;
      buf_d[wt_idx] = push_id;
    end
    // A torn pointer (mid-transition sample) is ignored; the last good one stays.
    if (rp_s2_onehot) begin
      rp_d = rp_s2_q;
    end else begin
      rp_err_d = 1'b1;
    end
  end

  // State registers, including the read-pointer synchronizer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wt_q     <= BUFFER_WIDTH'(1);
      wt_o_q   <= BUFFER_WIDTH'(1);
      rp_s1_q  <= BUFFER_WIDTH'(1);
      rp_s2_q  <= BUFFER_WIDTH'(1);
      rp_q     <= BUFFER_WIDTH'(1);
      rr_q     <= '0;
      rp_err_q <= 1'b0;
    end else begin
      wt_q     <= wt_d;
      // Token trails the internal pointer by one cycle so data lands first.
      wt_o_q   <= wt_q;
      rp_s1_q  <= cluster_events_rp_i;
      rp_s2_q  <= rp_s1_q;
      rp_q     <= rp_d;
      rr_q     <= rr_d;
      rp_err_q <= rp_err_d;
    end
  end

  // Event storage; cleared on reset so the read mux shows zero afterwards.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < BUFFER_WIDTH; i++) buf_q[i] <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

  // AND-OR read mux on the raw cluster pointer; the slot it selects is
  // never rewritten while the consumer owns it, so no register is needed.
  generate
    for (gi = 0; gi < BUFFER_WIDTH; gi++) begin : g_da
      assign da_terms[gi] = buf_q[gi] & {EVNT_WIDTH{cluster_events_rp_i[gi]}};
    end
  endgenerate

  // OR-reduce the masked slots onto the data output.
  always_comb begin
    cluster_events_da_o = '0;
    for (int i = 0; i < BUFFER_WIDTH; i++) begin
      cluster_events_da_o = cluster_events_da_o | da_terms[i];
    end
  end

  assign cluster_events_wt_o = wt_o_q;
  assign fill_level_o        = wt_idx - rp_idx;
  assign rp_err_o            = rp_err_q;

endmodule
